// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM encoding and constants for the multi-cycle ALU.
// ALU_MC_MULDIV_EN selects whether MULU/DIVU use the iterative datapath.
package alu_mc_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NAND  = 4'd2;
  localparam logic [3:0] OP_NOR   = 4'd3;
  localparam logic [3:0] OP_ADDU  = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_EQUAL = 4'd7;
  localparam logic [3:0] OP_SFT   = 4'd8;
  localparam logic [3:0] OP_SFTV  = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_MULU  = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2
  } state_t;

  // Divide-by-zero quotient is this bit replicated across the result width.
  localparam logic DIVZ_FILL = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// The first step runs on the start edge, so finish rises WIDTH-1 cycles later.
module alu_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             finish,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             div_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH-1:0] hi_s, lo_s, opnd_s;
  logic             div_s;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             step;

  // hi holds partial product / remainder, lo holds multiplier / dividend-quotient.
  always_comb begin
    hi_s    = start ? '0 : hi_q;
    lo_s    = start ? opa : lo_q;
    opnd_s  = start ? opb : opnd_q;
    div_s   = start ? is_div : div_q;
    sum     = {1'b0, hi_s} + (lo_s[0] ? {1'b0, opnd_s} : '0);
    shifted = {hi_s, lo_s[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opnd_s;
    res_hi  = sum[WIDTH:1];
    res_lo  = {sum[0], lo_s[WIDTH-1:1]};
    if (div_s) begin
      if (shifted >= {1'b0, opnd_s}) begin
        res_hi = diff;
        res_lo = {lo_s[WIDTH-2:0], 1'b1};
      end else begin
        res_hi = shifted[WIDTH-1:0];
        res_lo = {lo_s[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign step   = start || (cnt_q != '0);
  assign finish = (cnt_q == SHW'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q   <= res_hi;
      lo_q   <= res_lo;
      opnd_q <= opnd_s;
      div_q  <= div_s;
      cnt_q  <= start ? SHW'(WIDTH - 1) : cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshake and registered results.
// Define ALU_MC_MULDIV_EN to enable iterative MULU/DIVU (alu_muldiv_iter).
//
// state | meaning
// IDLE  | ready_o=1, waiting for valid_i
// EXEC  | result registers hold the new value, done_o=1
// ITER  | multiply/divide stepping one bit per cycle, inputs ignored
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             done_o
);

  state_t state_q, state_d;

  logic                    accept;
  logic                    go_iter;
  logic                    iter_done;
  logic [WIDTH-1:0]        op_res, op_hi;
  logic [WIDTH-1:0]        iter_lo, iter_hi;
  logic                    lt_s;
  logic signed [WIDTH-1:0] src2_sgn;

  assign accept   = valid_i && ready_o;
  assign ready_o  = (state_q == ST_IDLE);
  assign done_o   = (state_q == ST_EXEC);
  assign lt_s     = $signed(src1_i) < $signed(src2_i);
  assign src2_sgn = $signed(src2_i);

  always_comb begin
    op_res = '0;
    op_hi  = '0;
    case (ctrl_i)
      OP_AND:   op_res = src1_i & src2_i;
      OP_OR:    op_res = src1_i | src2_i;
      OP_NAND:  op_res = ~(src1_i & src2_i);
      OP_NOR:   op_res = ~(src1_i | src2_i);
      OP_ADDU:  op_res = src1_i + src2_i;
      OP_SUBU:  op_res = src1_i - src2_i;
      OP_SLT:   op_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_EQUAL: op_res = {{(WIDTH-1){1'b0}}, src1_i == src2_i};
      OP_SFT:   op_res = src2_sgn >>> shamt_i;
      OP_SFTV:  op_res = src2_sgn >>> src1_i[SHW-1:0];
      OP_LUI:   op_res = {src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
`ifdef ALU_MC_MULDIV_EN
      OP_DIVU: begin
        op_res = {WIDTH{DIVZ_FILL}};
        op_hi  = src1_i;
      end
`endif
      default: begin
        op_res = '0;
        op_hi  = '0;
      end
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  // Divide by zero bypasses the iterative path and completes through EXEC.
  assign go_iter = (ctrl_i == OP_MULU) ||
                   ((ctrl_i == OP_DIVU) && (src2_i != '0));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (accept && go_iter),
    .is_div (ctrl_i == OP_DIVU),
    .opa    (src1_i),
    .opb    (src2_i),
    .finish (iter_done),
    .res_lo (iter_lo),
    .res_hi (iter_hi)
  );
`else
  assign go_iter   = 1'b0;
  assign iter_done = 1'b0;
  assign iter_lo   = '0;
  assign iter_hi   = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i) state_d = go_iter ? ST_ITER : ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      ST_ITER: if (iter_done) state_d = ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Single-cycle results land on the accept edge so they are visible with done_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_o <= '0;
      hi_o     <= '0;
      zero_o   <= 1'b1;
    end else if (accept && !go_iter) begin
      result_o <= op_res;
      hi_o     <= op_hi;
      zero_o   <= (op_res == '0);
    end else if ((state_q == ST_ITER) && iter_done) begin
      result_o <= iter_lo;
      hi_o     <= iter_hi;
      zero_o   <= (iter_lo == '0);
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes expectations, monitor checks on done_o.
// Expectations follow ALU_MC_MULDIV_EN when it is defined for the build.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int ITER_LAT = MD ? WIDTH : 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] src1_i = '0;
  logic [WIDTH-1:0] src2_i = '0;
  logic [SHW-1:0]   shamt_i = '0;
  logic [3:0]       ctrl_i = '0;
  logic [WIDTH-1:0] result_o, hi_o;
  logic             zero_o, done_o;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .ctrl_i   (ctrl_i),
    .result_o (result_o),
    .hi_o     (hi_o),
    .zero_o   (zero_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i && done_o) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL spurious_done: result_o=%h hi_o=%h with no op pending", result_o, hi_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_res"},   result_o, e.res);
        check({e.name, "_hi"},    hi_o, e.hi);
        check({e.name, "_zero"},  {31'b0, zero_o}, {31'b0, e.res == 32'h0});
        check({e.name, "_lat"},   32'(cyc + 1 - e.acc), 32'(e.lat));
        check({e.name, "_ready"}, {31'b0, ready_o}, 32'h0);
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] eres,
                       input logic [31:0] ehi, input int elat, output int acc);
    int guard;
    exp_t e;
    @(negedge clk_i);
    valid_i = 1'b1;
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    shamt_i = sh;
    guard   = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    acc = -1;
    if (!ready_o) begin
      n_total++;
      $display("FAIL %s_accept: ready_o=0 after %0d cycles, required 1", name, guard);
      valid_i = 1'b0;
    end else begin
      acc    = cyc + 1;
      e.name = name;
      e.res  = eres;
      e.hi   = ehi;
      e.lat  = elat;
      e.acc  = acc;
      sb.push_back(e);
      @(posedge clk_i);
    end
  endtask

  task automatic idle();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  int a0, a1, a2;

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_res",   result_o, 32'h0);
    check("rst_zero",  {31'b0, zero_o}, 32'h1);
    check("rst_done",  {31'b0, done_o}, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'b0, ready_o}, 32'h1);

    issue("addu_wrap", OP_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1, a0);
    issue("slt",   OP_SLT,   32'h8000_0000, 32'h1, 5'd0, 32'h1, 32'h0, 1, a0);
    issue("sft",   OP_SFT,   32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'h0, 1, a0);
    issue("and",   OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 32'h0, 1, a0);
    issue("or",    OP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 32'h0, 1, a0);
    issue("nand",  OP_NAND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FFF_0FFF, 32'h0, 1, a0);
    issue("nor",   OP_NOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 32'h0, 1, a0);
    issue("subu",  OP_SUBU,  32'h3, 32'h5, 5'd0, 32'hFFFF_FFFE, 32'h0, 1, a0);
    issue("equal", OP_EQUAL, 32'h5, 32'h5, 5'd0, 32'h1, 32'h0, 1, a0);
    issue("sftv",  OP_SFTV,  32'h24, 32'h8000_0010, 5'd0, 32'hF800_0001, 32'h0, 1, a0);
    issue("lui",   OP_LUI,   32'h0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 32'h0, 1, a0);
    issue("op15",  4'd15,    32'h1234, 32'h5678, 5'd3, 32'h0, 32'h0, 1, a0);
    idle();

    issue("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,
          MD ? 32'h0000_0001 : 32'h0, MD ? 32'hFFFF_FFFE : 32'h0, ITER_LAT, a0);
    issue("mulu_3x4", OP_MULU, 32'h3, 32'h4, 5'd0, MD ? 32'hC : 32'h0, 32'h0, ITER_LAT, a0);
    issue("mulu_hi1", OP_MULU, 32'h0001_0000, 32'h0001_0000, 5'd0,
          32'h0, MD ? 32'h1 : 32'h0, ITER_LAT, a0);
    issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd0,
          MD ? 32'd14 : 32'h0, MD ? 32'd2 : 32'h0, ITER_LAT, a0);
    issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd0,
          MD ? 32'hFFFF_FFFF : 32'h0, MD ? 32'd5 : 32'h0, 1, a0);
    idle();

    // Operands wiggle while busy; only the first product may come out.
    issue("mulu_ignore", OP_MULU, 32'd6, 32'd7, 5'd0, MD ? 32'd42 : 32'h0, 32'h0, ITER_LAT, a0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o || ready_o) break;
      ctrl_i = OP_ADDU;
      src1_i = 32'(i + 1);
      src2_i = 32'(3 * i + 9);
    end
    valid_i = 1'b0;

    issue("b2b_and",  OP_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'h0F0F_0000, 32'h0, 1, a0);
    issue("b2b_or",   OP_OR,   32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 32'h0, 1, a1);
    issue("b2b_addu", OP_ADDU, 32'h1, 32'h1, 5'd0, 32'h2, 32'h0, 1, a2);
    idle();
    check("b2b_gap1", 32'(a1 - a0), 32'd2);
    check("b2b_gap2", 32'(a2 - a1), 32'd2);

    // Reset in the middle of a divide: the pending result must never appear.
    issue("divu_rst", OP_DIVU, 32'd100, 32'd7, 5'd0,
          MD ? 32'd14 : 32'h0, MD ? 32'd2 : 32'h0, ITER_LAT, a0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    sb.delete();
    #1;
    check("midrst_res",  result_o, 32'h0);
    check("midrst_hi",   hi_o, 32'h0);
    check("midrst_zero", {31'b0, zero_o}, 32'h1);
    check("midrst_done", {31'b0, done_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_ready", {31'b0, ready_o}, 32'h1);
    issue("addu_3_4", OP_ADDU, 32'd3, 32'd4, 5'd0, 32'd7, 32'h0, 1, a0);
    idle();

    begin
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
        @(negedge clk_i);
        guard++;
      end
      if (sb.size() != 0) begin
        n_total++;
        $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
    end
    repeat (40) @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU. Next generation of the datapath ALU: generic WIDTH, registered outputs, valid/ready handshake.
- Adds iterative unsigned multiply/divide and a separate high-half result.
- Sits in the EX stage. Single-cycle ops complete in 1 cycle; MULU/DIVU stall the pipeline through ready_o.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  block can accept; high only in IDLE.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- shamt_i  in  SHW  immediate shift amount for SFT.
- ctrl_i  in  4  opcode.
- result_o  out  WIDTH  main result (low product / quotient).
- hi_o  out  WIDTH  high product / remainder; 0 for other ops.
- zero_o  out  1  result_o == 0, registered with result_o.
- done_o  out  1  one-cycle pulse when result_o/hi_o update.

Behaviour:
- Opcodes: AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7, SFT=8, SFTV=9, LUI=10, MULU=11, DIVU=12.
- Opcodes 13-15: result_o=0, hi_o=0, complete in 1 cycle.
- Accept on valid_i && ready_o; operands and ctrl are captured at accept. Inputs are ignored while busy.
- States and transitions:
  - IDLE: accept goes to EXEC (single-cycle op) or ITER (MULU/DIVU).
  - EXEC: result registered, done_o=1, then IDLE. Latency is 1 cycle from accept to done_o.
  - ITER: counter runs WIDTH-1 down to 0, one bit per cycle. At 0, results are written, done_o=1, then IDLE. Latency is WIDTH cycles; ready_o=0 throughout ITER.
- Arithmetic rules:
  - ADDU/SUBU wrap modulo 2^WIDTH.
  - SLT is signed: {0..., src1<src2}.
  - EQUAL: {0..., src1==src2}.
  - SFT: src2 >>> shamt_i (arithmetic).
  - SFTV: src2 >>> src1[SHW-1:0].
  - LUI: {src2[WIDTH/2-1:0], WIDTH/2 zeros}.
- MULU: 2*WIDTH-bit unsigned product; hi_o = upper half, result_o = lower half. Shift-add.
- DIVU: restoring unsigned division; result_o = quotient, hi_o = remainder.
- Divide by zero: skips ITER and completes in 1 cycle via EXEC with result_o = all ones, hi_o = src1.
- result_o, hi_o and zero_o hold their values between completions.
- done_o and ready_o are never high in the same cycle as an accept's completion. A new accept is possible on the cycle after done_o.
- Reset values (also for reset asserted mid-ITER): state IDLE, result_o=0, hi_o=0, zero_o=1, done_o=0, ready_o=1 after release. An in-flight operation is discarded.

Optional Feature:
- Macro: ALU_MC_MULDIV_EN.
- Defined: MULU/DIVU behave as above and the iterative datapath is present.
- Undefined: no iterative logic and no ITER state. MULU/DIVU are treated as undefined opcodes (1 cycle, result 0, hi 0). ready_o returns to 1 one cycle after each accept.

Decomposition:
- Package alu_mc_pkg holds:
  - opcode localparams,
  - state encoding (IDLE, EXEC, ITER),
  - the divide-by-zero quotient constant.
- Sub-module alu_muldiv_iter, instantiated only under ALU_MC_MULDIV_EN. It holds the shift-add/restore datapath, the counter and start/finish signals. The top keeps the FSM, combinational ops and output registers.

Test Plan:
- Reset held low mid-DIVU (after 5 cycles), then released -> outputs 0, zero_o=1, ready_o=1; next ADDU 3+4 -> result 7 after 1 cycle.
- ADDU 0xFFFFFFFF+1 -> result 0, zero_o=1, done_o one cycle after accept. SLT 0x80000000 vs 1 -> 1. SFT src2=0x80000000, shamt=4 -> 0xF8000000.
- MULU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, result_o=0x00000001. done_o exactly 32 cycles after accept; ready_o=0 for those cycles.
- DIVU 100/7 -> result 14, hi 2 after 32 cycles. DIVU 5/0 -> result 0xFFFFFFFF, hi 5 after 1 cycle.
- valid_i held high with changing operands during ITER -> ignored; only the first operation's result appears. Back-to-back single-cycle ops -> one accept every 2 cycles.
- Build without ALU_MC_MULDIV_EN: MULU 3*4 -> result 0, hi 0, done_o after 1 cycle. Opcode 15 -> result 0 in both builds.
